// File: rtl/instr_issue_ctrl.sv
// instr_issue_ctrl: single-issue instruction controller. It accepts one
// instruction word, decodes it, waits one cycle for the external ALU
// result and writes that result back to the register file. A legal
// instruction takes four cycles: IDLE, DECODE, EXEC, WB.
module instr_issue_ctrl #(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32,
  parameter int IMM_IN = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DWIDTH-1:0] ALUresult,
  output logic [RWIDTH-1:0] rs,
  output logic [RWIDTH-1:0] rt,
  output logic [RWIDTH-1:0] rd,
  output logic [DWIDTH-1:0] wd,
  output logic              we,
  output logic              muxsel1,
  output logic [IMM_IN-1:0] imm_in,
  output logic [3:0]        ALUopsel,
  output logic              done,
  output logic              illegal,
  output logic [15:0]       retired_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              run_q;      // 0 while in reset, 1 from the first clk edge after it
  logic [31:0]       instr_q;    // instruction in flight
  logic [4:0]        opcode;
  logic              is_rtype;
  logic              is_itype;
  logic              legal;
  logic [RWIDTH-1:0] dest;

  // Decode is a pure function of the captured word, so the operand fields
  // stay stable through EXEC and hold their last values in IDLE.
  assign opcode   = instr_q[31:27];
  assign is_rtype = (opcode == 5'b00000);
  assign is_itype = opcode[4];
  assign legal    = is_rtype | is_itype;
  assign dest     = is_itype ? instr_q[20:15] : instr_q[14:9];

  assign rs       = instr_q[26:21];
  assign rt       = instr_q[20:15];
  assign imm_in   = instr_q[14:0];
  assign muxsel1  = is_itype;
  assign ALUopsel = is_itype ? opcode[3:0] : instr_q[3:0];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Keeps instr_ready low while reset is held even though the FSM sits in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Next-state logic.
  // NOTE: defaulting state_d before the case keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (instr_valid && instr_ready) state_d = DECODE;
      DECODE:  state_d = legal ? EXEC : IDLE;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state strobes. They decode the asynchronously reset state register,
  // so reset drops we immediately, without waiting for a clock edge.
  always_comb begin
    instr_ready = 1'b0;
    illegal     = 1'b0;
    done        = 1'b0;
    we          = 1'b0;
    unique case (state_q)
      IDLE:    instr_ready = run_q;
      DECODE:  illegal     = ~legal;
      EXEC:    ;
      WB: begin
        done = 1'b1;
        we   = (rd != '0);
      end
      default: ;
    endcase
  end

  // Datapath registers: captured instruction, write-back target and data, retire counter.
  // NOTE: every register here is reset, including the captured instruction,
  // so the decoded outputs come up as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q     <= '0;
      rd          <= '0;
      wd          <= '0;
      retired_cnt <= '0;
    end else begin
      if (instr_valid && instr_ready) begin
        instr_q <= instr;
      end
      if (state_q == EXEC) begin
        wd <= ALUresult;
        rd <= dest;
      end
      if (state_q == WB) begin
        retired_cnt <= retired_cnt + 16'd1;
      end
    end
  end

endmodule
